// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and one-outstanding fetch FSM feeding ID; optional PC_ADDR_ERR_EN traps misaligned PCs.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect_en,
  input  logic [31:0] i_redirect_addr,
  input  logic        i_flush,
  input  logic [31:0] i_flush_addr,
  input  logic        i_id_stall,
  output logic        o_inst_req,
  output logic [31:0] o_inst_addr,
  input  logic        i_inst_addr_ok,
  input  logic [31:0] i_inst_rdata,
  input  logic        i_inst_data_ok,
  output logic        o_if_valid,
  output logic [31:0] o_if_inst,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_next_instaddress,
  output logic        o_fetch_adel
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;
`ifdef PC_ADDR_ERR_EN
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif
  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_pend_addr, r_buf, r_if_pc, w_pc_nxt;
  logic        r_pend_v, r_drop, w_pc_ok, w_hs, w_data, w_err;
`ifdef PC_ADDR_ERR_EN
  assign w_pc_ok      = r_pc[1:0] == 2'b00;
  assign o_fetch_adel = r_state == S_ERR;
`else
  assign w_pc_ok      = 1'b1;
  assign o_fetch_adel = 1'b0;
`endif
  assign o_inst_req         = i_rst_n && r_state == S_REQ && w_pc_ok;
  assign o_inst_addr        = r_pc;
  assign o_if_valid         = r_state == S_HOLD || r_state == S_ERR;
  assign o_if_inst          = r_buf;
  assign o_if_pc            = r_if_pc;
  assign o_next_instaddress = r_if_pc + 32'd4;
  assign w_hs   = o_inst_req && i_inst_addr_ok;
  assign w_data = r_state == S_WAIT && i_inst_data_ok;
  assign w_err  = r_state == S_REQ && !w_pc_ok && !i_flush;
  // flush beats a same-cycle redirect; a redirect at the handshake skips the pending slot
  assign w_pc_nxt = (i_flush ? i_flush_addr : i_redirect_en ? i_redirect_addr :
                     r_pend_v ? r_pend_addr : r_pc + 32'd4) & PC_MASK;
  // state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_REQ;
    else r_state <= w_state_nxt;
  // next state: flush aborts the held word, or leaves a request in flight to be dropped
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ:   w_state_nxt = w_err ? S_ERR : w_hs ? S_WAIT : S_REQ;
      S_WAIT:  w_state_nxt = !i_inst_data_ok ? S_WAIT : (r_drop || i_flush) ? S_REQ : S_HOLD;
      S_HOLD:  w_state_nxt = (i_flush || !i_id_stall) ? S_REQ : S_HOLD;
      default: w_state_nxt = i_flush ? S_REQ : S_ERR;
    endcase
  end
  // PC, pending redirect, drop flag and the word/PC presented to ID
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pc        <= RESET_VECTOR & PC_MASK;
      r_pend_v    <= 1'b0;
      r_pend_addr <= EXC_VECTOR;
      r_drop      <= 1'b0;
      r_buf       <= '0;
      r_if_pc     <= '0;
    end else begin
      if (i_flush || w_hs) r_pc <= w_pc_nxt;
      r_pend_v <= !i_flush && !w_hs && (i_redirect_en || r_pend_v);
      if (i_redirect_en) r_pend_addr <= i_redirect_addr;
      r_drop <= (i_flush && ((r_state == S_WAIT && !i_inst_data_ok) || w_hs)) || (r_drop && !w_data);
      if (w_hs || w_err) r_if_pc <= r_pc;
      if (w_err) r_buf <= '0;
      else if (w_data && !r_drop && !i_flush) r_buf <= i_inst_rdata;
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vector table, corner sequences and randomized run against a transaction model.
module tb_pc_fetch_unit;
  localparam logic        H = 1'b1;
  localparam logic        L = 1'b0;
  localparam logic [31:0] Z = 32'h0;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        redirect_en = 1'b0, flush = 1'b0, id_stall = 1'b0, inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] redirect_addr = '0, flush_addr = '0, inst_rdata = '0;
  logic        inst_req, if_valid, fetch_adel;
  logic [31:0] inst_addr, if_inst, if_pc, next_instaddress;
  int          n_chk = 0, n_fail = 0;
  typedef struct {
    logic aok; logic dok; logic [31:0] rd; logic st; logic rde; logic [31:0] ra;
    logic fl; logic [31:0] fa; logic er; logic [31:0] ea; logic ev; logic [31:0] ep; logic [31:0] ei;
  } vec_t;
  vec_t tv[$];

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_redirect_en(redirect_en), .i_redirect_addr(redirect_addr),
    .i_flush(flush), .i_flush_addr(flush_addr), .i_id_stall(id_stall),
    .o_inst_req(inst_req), .o_inst_addr(inst_addr), .i_inst_addr_ok(inst_addr_ok),
    .i_inst_rdata(inst_rdata), .i_inst_data_ok(inst_data_ok), .o_if_valid(if_valid),
    .o_if_inst(if_inst), .o_if_pc(if_pc), .o_next_instaddress(next_instaddress),
    .o_fetch_adel(fetch_adel)
  );

  function automatic vec_t v(input logic aok, dok, input logic [31:0] rd, input logic st, rde,
                             input logic [31:0] ra, input logic fl, input logic [31:0] fa,
                             input logic er, input logic [31:0] ea, input logic ev,
                             input logic [31:0] ep, ei);
    return '{aok, dok, rd, st, rde, ra, fl, fa, er, ea, ev, ep, ei};
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic aok, dok, input logic [31:0] rd, input logic st, rde,
                     input logic [31:0] ra, input logic fl, input logic [31:0] fa);
    inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd; id_stall = st;
    redirect_en = rde; redirect_addr = ra; flush = fl; flush_addr = fa;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    drv(L, L, Z, L, L, Z, L, Z);
    rst_n = 1'b0;
    #1;
    chk1("rst_inst_req", inst_req, L);
    chk1("rst_if_valid", if_valid, L);
    chk32("rst_if_inst", if_inst, Z);
    chk32("rst_if_pc", if_pc, Z);
    chk1("rst_fetch_adel", fetch_adel, L);
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic        req, aok, dok, st, rde, fl, hs, m_pend;
    logic [31:0] rd, ra, fa, m_pc, m_pa, ep, mem_addr;
    logic [31:0] q[$];
    int          mem_lat, n_del;
    logic        mem_busy;
    tv.push_back(v(H,L,Z,L,L,Z,L,Z, H,32'hBFC0_0000,L,Z,Z));
    tv.push_back(v(L,H,32'h1111_0000,L,L,Z,L,Z, L,Z,L,Z,Z));
    tv.push_back(v(L,L,Z,L,L,Z,L,Z, L,Z,H,32'hBFC0_0000,32'h1111_0000));
    tv.push_back(v(H,L,Z,L,L,Z,L,Z, H,32'hBFC0_0004,L,Z,Z));
    tv.push_back(v(L,H,32'h2222_0001,L,L,Z,L,Z, L,Z,L,Z,Z));
    tv.push_back(v(L,L,Z,L,L,Z,L,Z, L,Z,H,32'hBFC0_0004,32'h2222_0001));
    tv.push_back(v(L,L,Z,L,H,32'h8000_0100,L,Z, H,32'hBFC0_0008,L,Z,Z));
    tv.push_back(v(H,L,Z,L,L,Z,L,Z, H,32'hBFC0_0008,L,Z,Z));
    tv.push_back(v(L,H,32'h3333_0002,L,L,Z,L,Z, L,Z,L,Z,Z));
    tv.push_back(v(L,L,Z,L,L,Z,L,Z, L,Z,H,32'hBFC0_0008,32'h3333_0002));
    tv.push_back(v(H,L,Z,L,L,Z,L,Z, H,32'h8000_0100,L,Z,Z));
    tv.push_back(v(L,H,32'h4444_0003,L,L,Z,L,Z, L,Z,L,Z,Z));
    for (int i = 0; i < 5; i++) tv.push_back(v(L,L,Z,H,L,Z,L,Z, L,Z,H,32'h8000_0100,32'h4444_0003));
    tv.push_back(v(L,L,Z,L,L,Z,L,Z, L,Z,H,32'h8000_0100,32'h4444_0003));
    tv.push_back(v(H,L,Z,L,L,Z,L,Z, H,32'h8000_0104,L,Z,Z));
    tv.push_back(v(L,L,Z,L,L,Z,H,32'hBFC0_0380, L,Z,L,Z,Z));
    tv.push_back(v(L,H,32'hDEAD_BEEF,L,L,Z,L,Z, L,Z,L,Z,Z));
    tv.push_back(v(L,L,Z,L,H,32'h8000_0200,H,32'hBFC0_0400, H,32'hBFC0_0380,L,Z,Z));
    tv.push_back(v(H,L,Z,L,L,Z,L,Z, H,32'hBFC0_0400,L,Z,Z));
    tv.push_back(v(L,H,32'h5555_0004,L,L,Z,L,Z, L,Z,L,Z,Z));
    tv.push_back(v(L,L,Z,L,L,Z,L,Z, L,Z,H,32'hBFC0_0400,32'h5555_0004));
    tv.push_back(v(H,L,Z,L,H,32'hFFFF_FFFC,L,Z, H,32'hBFC0_0404,L,Z,Z));
    tv.push_back(v(L,H,32'h6666_0005,L,L,Z,L,Z, L,Z,L,Z,Z));
    tv.push_back(v(L,L,Z,L,L,Z,L,Z, L,Z,H,32'hBFC0_0404,32'h6666_0005));
    tv.push_back(v(H,L,Z,L,L,Z,L,Z, H,32'hFFFF_FFFC,L,Z,Z));
    tv.push_back(v(L,H,32'h7777_0006,L,L,Z,L,Z, L,Z,L,Z,Z));
    tv.push_back(v(L,L,Z,L,L,Z,L,Z, L,Z,H,32'hFFFF_FFFC,32'h7777_0006));
    tv.push_back(v(L,L,Z,L,L,Z,L,Z, H,32'h0000_0000,L,Z,Z));
    #2;
    do_reset();
    foreach (tv[i]) begin
      chk1($sformatf("tv%0d_req", i), inst_req, tv[i].er);
      chk1($sformatf("tv%0d_valid", i), if_valid, tv[i].ev);
      chk1($sformatf("tv%0d_adel", i), fetch_adel, L);
      if (tv[i].er) chk32($sformatf("tv%0d_addr", i), inst_addr, tv[i].ea);
      if (tv[i].ev) begin
        chk32($sformatf("tv%0d_pc", i), if_pc, tv[i].ep);
        chk32($sformatf("tv%0d_inst", i), if_inst, tv[i].ei);
        chk32($sformatf("tv%0d_nia", i), next_instaddress, tv[i].ep + 32'd4);
      end
      drv(tv[i].aok, tv[i].dok, tv[i].rd, tv[i].st, tv[i].rde, tv[i].ra, tv[i].fl, tv[i].fa);
      step();
    end
    do_reset();
    drv(H, L, Z, L, L, Z, L, Z); step();
    chk1("fd_wait_req", inst_req, L);
    drv(L, H, 32'hCAFE_0001, L, L, Z, H, 32'hBFC0_0380); step();
    chk1("fd_valid", if_valid, L);
    chk1("fd_req", inst_req, H);
    chk32("fd_addr", inst_addr, 32'hBFC0_0380);
    drv(H, L, Z, L, L, Z, L, Z); step();
    drv(L, H, 32'h1234_5678, H, L, Z, L, Z); step();
    chk1("fd_nodrop_valid", if_valid, H);
    chk32("fd_nodrop_pc", if_pc, 32'hBFC0_0380);
    chk32("fd_nodrop_inst", if_inst, 32'h1234_5678);
    drv(L, L, Z, H, L, Z, H, 32'hBFC0_0500); step();
    chk1("fh_valid", if_valid, L);
    chk1("fh_req", inst_req, H);
    chk32("fh_addr", inst_addr, 32'hBFC0_0500);
`ifdef PC_ADDR_ERR_EN
    do_reset();
    drv(H, L, Z, L, H, 32'h8000_0102, L, Z); step();
    drv(L, H, 32'h0BAD_0001, L, L, Z, L, Z); step();
    chk32("ae_prev_pc", if_pc, 32'hBFC0_0000);
    drv(L, L, Z, L, L, Z, L, Z); step();
    chk1("ae_no_req", inst_req, L);
    step();
    chk1("ae_adel", fetch_adel, H);
    chk1("ae_valid", if_valid, H);
    chk32("ae_pc", if_pc, 32'h8000_0102);
    chk32("ae_inst", if_inst, Z);
    chk1("ae_req", inst_req, L);
    step();
    chk1("ae_hold", fetch_adel, H);
    drv(L, L, Z, L, L, Z, H, 32'hBFC0_0380); step();
    chk1("ae_clear", fetch_adel, L);
    chk1("ae_flush_req", inst_req, H);
    chk32("ae_flush_addr", inst_addr, 32'hBFC0_0380);
`endif
    do_reset();
    m_pc = 32'hBFC0_0000; m_pend = 1'b0; m_pa = '0; q.delete();
    mem_busy = 1'b0; mem_lat = 0; mem_addr = '0; n_del = 0;
    for (int c = 0; c < 4000; c++) begin
      req = inst_req;
      aok = req && !mem_busy && $urandom_range(2) != 0;
      dok = mem_busy && mem_lat == 0;
      rd  = dok ? memf(mem_addr) : $urandom;
      st  = $urandom_range(2) == 0;
      rde = $urandom_range(7) == 0;
      ra  = $urandom & 32'hFFFF_FFFC;
      fl  = $urandom_range(24) == 0;
      fa  = $urandom & 32'hFFFF_FFFC;
      hs  = req && aok;
      if (mem_busy) chk1("one_outstanding", req, L);
      chk1("adel_zero", fetch_adel, L);
      if (if_valid && !st && !fl) begin
        chk1("deliver_has_fetch", q.size() != 0, H);
        if (q.size() != 0) begin
          ep = q.pop_front();
          chk32("deliver_pc", if_pc, ep);
          chk32("deliver_inst", if_inst, memf(ep));
          chk32("deliver_nia", next_instaddress, ep + 32'd4);
          n_del++;
        end
      end
      if (hs) chk32("fetch_addr", inst_addr, m_pc);
      if (fl) begin
        q.delete(); m_pend = 1'b0; m_pc = fa;
      end else if (hs) begin
        q.push_back(m_pc);
        m_pc = rde ? ra : m_pend ? m_pa : m_pc + 32'd4;
        m_pend = 1'b0;
      end else if (rde) begin
        m_pend = 1'b1; m_pa = ra;
      end
      if (dok) mem_busy = 1'b0;
      if (hs) begin
        mem_busy = 1'b1; mem_addr = inst_addr; mem_lat = $urandom_range(2);
      end else if (mem_busy && mem_lat != 0) mem_lat--;
      drv(aok, dok, rd, st, rde, ra, fl, fa);
      step();
    end
    chk1("deliveries", n_del > 100, H);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
